// File: rtl/lift_car_dispatcher.sv
// lift_car_dispatcher
// Car-side serving end of the lift interface. Floor requests arrive as a
// one-hot SW value qualified by a KEY0 press (active-low, asynchronous),
// are held in a pending mask, and are served in SCAN order: the car keeps
// its travel direction while requests remain ahead of it, stopping to open
// the door for a timed interval at every requested floor.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   SW[8:0]    in   one-hot floor select
//   KEY0       in   request strobe, active low, asynchronous
//   LED_G      out  door open
//   LED_R      out  door closed (~LED_G)
//   floor_cur  out  current floor, binary
//   moving     out  car travelling between floors
//   dir_up     out  current / last travel direction (1 = up)
//   pending    out  outstanding request mask
module lift_car_dispatcher #(
  parameter int N_FLOORS    = 9,
  parameter int STEP_CYCLES = 50000000,
  parameter int DOOR_CYCLES = 150000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic [8:0] SW,
  input  logic       KEY0,
  output logic       LED_G,
  output logic       LED_R,
  output logic [3:0] floor_cur,
  output logic       moving,
  output logic       dir_up,
  output logic [8:0] pending
);

  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam int DOOR_W = $clog2(DOOR_CYCLES);
  localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
  localparam logic [DOOR_W-1:0] DOOR_LOAD = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [8:0] FLOOR_MASK = 9'((1 << N_FLOORS) - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t            state_q, state_d;
  logic [3:0]        floor_q, floor_d;
  logic [8:0]        pend_q, pend_d;
  logic              dir_q, dir_d;
  logic              moving_q, moving_d;
  logic              led_g_q, led_g_d;
  logic              led_r_q, led_r_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [DOOR_W-1:0] door_q, door_d;

  // KEY0 synchroniser; s3 is the previous synchronised value for edge detect
  logic key_s1_q, key_s2_q, key_s3_q;
  logic key_fall;
  assign key_fall = key_s3_q & ~key_s2_q;

  // Request decode: exactly one bit set and within the floor range
  logic       sw_ok;
  logic [3:0] sw_idx;
  logic       req_vld;
  logic [8:0] req_mask;

  always_comb begin
    sw_ok  = (SW != 9'd0) && ((SW & (SW - 9'd1)) == 9'd0) &&
             ((SW & ~FLOOR_MASK) == 9'd0);
    sw_idx = 4'd0;
    for (int i = 0; i < 9; i++)
      if (SW[i]) sw_idx = 4'(i);
  end

  assign req_vld  = key_fall & sw_ok;
  assign req_mask = req_vld ? (9'd1 << sw_idx) : 9'd0;

  function automatic logic any_above(input logic [8:0] m, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 9; i++)
      if (m[i] && (4'(i) > f)) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [8:0] m, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 9; i++)
      if (m[i] && (4'(i) < f)) r = 1'b1;
    return r;
  endfunction

  logic       above, below, go_up, go_dn;
  logic [3:0] next_floor;

  always_comb begin
    above      = any_above(pend_q, floor_q);
    below      = any_below(pend_q, floor_q);
    go_up      = above && (dir_q || !below);
    go_dn      = below && (!dir_q || !above);
    next_floor = dir_q ? floor_q + 4'd1 : floor_q - 4'd1;

    state_d  = state_q;
    floor_d  = floor_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    led_g_d  = led_g_q;
    step_d   = step_q;
    door_d   = door_q;

    case (state_q)
      S_IDLE: begin
        if (req_vld && sw_idx == floor_q) begin
          state_d = S_DOOR;
          led_g_d = 1'b1;
          door_d  = DOOR_LOAD;
        end else begin
          pend_d = pend_q | req_mask;
          if (go_up || go_dn) begin
            dir_d    = go_up;
            state_d  = S_MOVE;
            moving_d = 1'b1;
            step_d   = STEP_LOAD;
          end
        end
      end

      S_MOVE: begin
        // A request for the floor being left is kept for a later pass;
        // one for the arrival floor is folded in and served now.
        pend_d = pend_q | req_mask;
        if (step_q == '0) begin
          floor_d = next_floor;
          if (pend_d[next_floor]) begin
            pend_d[next_floor] = 1'b0;
            state_d  = S_DOOR;
            moving_d = 1'b0;
            led_g_d  = 1'b1;
            door_d   = DOOR_LOAD;
          end else if (dir_q ? any_above(pend_d, next_floor)
                             : any_below(pend_d, next_floor)) begin
            step_d = STEP_LOAD;
          end else begin
            state_d  = S_IDLE;
            moving_d = 1'b0;
          end
        end else begin
          step_d = step_q - 1'b1;
        end
      end

      S_DOOR: begin
        if (req_vld && sw_idx == floor_q) begin
          door_d = DOOR_LOAD;
        end else begin
          pend_d = pend_q | req_mask;
          if (door_q == '0) begin
            state_d = S_IDLE;
            led_g_d = 1'b0;
          end else begin
            door_d = door_q - 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    led_r_d = ~led_g_d;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      floor_q  <= 4'd0;
      pend_q   <= 9'd0;
      dir_q    <= 1'b1;
      moving_q <= 1'b0;
      led_g_q  <= 1'b0;
      led_r_q  <= 1'b1;
      step_q   <= '0;
      door_q   <= '0;
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_s3_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      led_g_q  <= led_g_d;
      led_r_q  <= led_r_d;
      step_q   <= step_d;
      door_q   <= door_d;
      key_s1_q <= KEY0;
      key_s2_q <= key_s1_q;
      key_s3_q <= key_s2_q;
    end
  end

  assign LED_G     = led_g_q;
  assign LED_R     = led_r_q;
  assign floor_cur = floor_q;
  assign moving    = moving_q;
  assign dir_up    = dir_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_lift_car_dispatcher.sv
// Bench for lift_car_dispatcher: a deadline-based reference model predicts
// every change of the observable tuple {floor, moving, dir, door, pending}
// and queues it with the cycle it should appear in; a monitor pops and
// compares whenever the DUT's tuple changes.
module tb_lift_car_dispatcher;

  localparam int NF   = 9;
  localparam int STEP = 4;
  localparam int DOOR = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] sw = 9'd0;
  logic       key0 = 1'b1;
  logic       led_g, led_r, moving, dir_up;
  logic [3:0] floor_cur;
  logic [8:0] pending;

  lift_car_dispatcher #(.N_FLOORS(NF), .STEP_CYCLES(STEP), .DOOR_CYCLES(DOOR)) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .KEY0(key0),
    .LED_G(led_g), .LED_R(led_r), .floor_cur(floor_cur), .moving(moving),
    .dir_up(dir_up), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [15:0] tup; int stamp; } exp_t;
  exp_t exp_q[$];

  localparam logic [15:0] RESET_TUP = {4'd0, 1'b0, 1'b1, 1'b0, 9'd0};

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 travelling, 2 door open. Timing kept as absolute
  // deadlines (cycle number of next arrival / door close).
  int          cyc = 0;
  int          m_mode = 0;
  int          m_floor = 0;
  bit          m_dir = 1'b1;
  bit          m_pend[NF];
  int          m_arrive = 0;
  int          m_door_end = 0;
  int          m_low = 0;
  logic [15:0] m_last = RESET_TUP;

  function automatic bit pend_above(int f);
    for (int i = f + 1; i < NF; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pend_below(int f);
    for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] model_tup();
    logic [8:0] m;
    m = 9'd0;
    for (int i = 0; i < NF; i++) m[i] = m_pend[i];
    return {4'(m_floor), m_mode == 1, m_dir, m_mode == 2, m};
  endfunction

  function automatic int decode_sw(logic [8:0] v);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < 9; i++) if (v[i]) begin n++; idx = i; end
    if (n != 1 || idx >= NF) return -1;
    return idx;
  endfunction

  task automatic model_push(int stamp);
    logic [15:0] t;
    exp_t e;
    t = model_tup();
    if (t !== m_last) begin
      e.tup = t; e.stamp = stamp;
      exp_q.push_back(e);
      m_last = t;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_floor = 0; m_dir = 1'b1; m_low = 0;
      for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
      model_push(-1);
    end else begin
      int req;
      bit up, dn;
      cyc++;
      // a press is recognised on the third consecutive low sample
      if (key0 == 1'b0) m_low++; else m_low = 0;
      req = (m_low == 3) ? decode_sw(sw) : -1;
      case (m_mode)
        0: begin
          if (req >= 0 && req == m_floor) begin
            m_mode = 2; m_door_end = cyc + DOOR;
          end else begin
            up = pend_above(m_floor) && (m_dir || !pend_below(m_floor));
            dn = pend_below(m_floor) && (!m_dir || !pend_above(m_floor));
            if (up || dn) begin
              m_dir = up; m_mode = 1; m_arrive = cyc + STEP;
            end
            if (req >= 0) m_pend[req] = 1'b1;
          end
        end
        1: begin
          if (req >= 0) m_pend[req] = 1'b1;
          if (cyc == m_arrive) begin
            m_floor = m_dir ? m_floor + 1 : m_floor - 1;
            if (m_pend[m_floor]) begin
              m_pend[m_floor] = 1'b0; m_mode = 2; m_door_end = cyc + DOOR;
            end else if (m_dir ? pend_above(m_floor) : pend_below(m_floor)) begin
              m_arrive = cyc + STEP;
            end else begin
              m_mode = 0;
            end
          end
        end
        default: begin
          if (req >= 0 && req == m_floor) m_door_end = cyc + DOOR;
          else begin
            if (req >= 0) m_pend[req] = 1'b1;
            if (cyc == m_door_end) m_mode = 0;
          end
        end
      endcase
      model_push(cyc);
    end
  end

  // ---------------- monitor ----------------
  logic [15:0] mon_last = RESET_TUP;

  initial begin
    logic [15:0] cur;
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (led_r !== ~led_g) begin
        errors++;
        $display("FAIL led_r_inv cyc=%0d got LED_R=%b want %b", cyc, led_r, ~led_g);
      end
      cur = {floor_cur, moving, dir_up, led_g, pending};
      if (cur !== mon_last) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got %h nothing expected", cyc, cur);
        end else begin
          e = exp_q.pop_front();
          if (e.tup !== cur || (e.stamp >= 0 && e.stamp != cyc)) begin
            errors++;
            $display("FAIL tuple cyc=%0d got %h want %h at cyc %0d", cyc, cur, e.tup, e.stamp);
          end
        end
        mon_last = cur;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [8:0] v, input int len);
    @(negedge clk);
    sw = v; key0 = 1'b0;
    repeat (len) @(negedge clk);
    key0 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  function automatic bit model_quiet();
    for (int i = 0; i < NF; i++) if (m_pend[i]) return 1'b0;
    return m_mode == 0;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (!model_quiet() && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout cyc=%0d got busy want idle", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({floor_cur, moving, dir_up, led_g, pending} !== RESET_TUP || led_r !== 1'b1) begin
      errors++;
      $display("FAIL reset_now got %h led_r=%b want %h led_r=1",
               {floor_cur, moving, dir_up, led_g, pending}, led_r, RESET_TUP);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [8:0] v;
    repeat (3) @(negedge clk);
    checks++;
    if ({floor_cur, moving, dir_up, led_g, pending} !== RESET_TUP || led_r !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got %h led_r=%b want %h led_r=1",
               {floor_cur, moving, dir_up, led_g, pending}, led_r, RESET_TUP);
    end
    #2 rst = 1'b0;

    // travel to floor 3, door, idle
    press(9'b000001000, 3);
    wait_idle();

    // malformed selects are ignored
    press(9'b000000101, 4);
    press(9'b000000000, 3);
    repeat (6) @(negedge clk);

    // same-floor request at floor 0, then extend the door
    do_reset();
    press(9'b000000001, 3);
    repeat (2) @(negedge clk);
    press(9'b000000001, 3);
    wait_idle();

    // SCAN: at 2 heading for 6, add 4 and 1 on the way
    press(9'b000000100, 3);
    wait_idle();
    press(9'b001000000, 3);
    press(9'b000010000, 3);
    press(9'b000000010, 3);
    wait_idle();

    // top floor
    press(9'b100000000, 5);
    wait_idle();
    press(9'b000000001, 3);
    wait_idle();

    // reset between floors 3 and 4
    do_reset();
    press(9'b000100000, 3);
    n = 0;
    while (!(m_floor == 3 && m_mode == 1) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL reach3_timeout cyc=%0d got floor %0d want 3", cyc, m_floor);
    end
    @(negedge clk);
    do_reset();
    press(9'b000000100, 3);
    wait_idle();

    // randomized requests, including malformed selects
    for (int k = 0; k < 60; k++) begin
      int r;
      r = int'($urandom_range(0, 10));
      if (r < NF) v = 9'd1 << r;
      else v = 9'($urandom);
      press(v, int'($urandom_range(3, 5)));
      repeat ($urandom_range(0, 10)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) wait_idle();
    end
    wait_idle();
    repeat (5) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect got %0d pending entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lift_car_dispatcher.md
Name: lift_car_dispatcher

Overview:
Car-side serving end of the lift interface. It accepts floor requests issued on SW/KEY0, holds them in a pending mask, and moves the car up and down one floor at a time using SCAN ordering: it keeps its current direction while requests remain ahead. At each served floor it opens the door for a timed interval. Its floor index drives the existing 7-segment decode, so the HEX logic stays outside this block.

Parameters:
N_FLOORS, 9, number of floors (0..N_FLOORS-1); max 9.
STEP_CYCLES, 50000000, clock cycles to travel one floor (>=2).
DOOR_CYCLES, 150000000, clock cycles the door stays open (>=2).

Ports:
CLOCK_50  input  1  system clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-high reset.
SW  input  9  one-hot floor select; bit i = floor i.
KEY0  input  1  request strobe, active-low push button, asynchronous to CLOCK_50.
LED_G  output  1  door open.
LED_R  output  1  door closed (always equal to ~LED_G).
floor_cur  output  4  current floor, binary.
moving  output  1  car travelling between floors.
dir_up  output  1  current or last travel direction (1 = up).
pending  output  9  outstanding request mask; bits >= N_FLOORS are always 0.

Behaviour:
- Reset (asynchronous, active-high), all registered:
  - state=IDLE, floor_cur=0, pending=0, dir_up=1, moving=0, LED_G=0, LED_R=1.
  - Both timers cleared; KEY0 synchroniser preset to 1 (released).
- Request capture:
  - KEY0 passes through a 2-flop synchroniser followed by a falling-edge detect.
  - The request becomes effective in the cycle after the detect: pending is updated on the 3rd rising edge after KEY0 is first sampled low.
  - SW must be exactly one-hot with index i < N_FLOORS. Zero-hot, multi-hot or out-of-range values are ignored with no state change.
  - If i == floor_cur and state is IDLE or DOOR: go to DOOR (or stay in it), reload the door timer, and leave pending[i] unset.
  - Otherwise set pending[i]. Setting an already-set bit is a no-op.
- State machine:
  - IDLE, pending==0: stay in IDLE.
  - IDLE, pending!=0, direction choice:
    - above = any pending bit > floor_cur; below = any pending bit < floor_cur.
    - Go up if above && (dir_up || !below).
    - Go down if below && (!dir_up || !above).
    - Update dir_up, load the step timer, enter MOVE with moving=1 in the next cycle.
  - MOVE: the step timer counts STEP_CYCLES cycles, then floor_cur increments or decrements by 1.
    - pending[new floor] set: clear it in the same edge, set moving=0 and LED_G=1, load the door timer, enter DOOR.
    - Otherwise, a request still ahead in dir_up: reload the step timer and stay in MOVE.
    - Otherwise: IDLE.
  - DOOR: LED_G=1 for DOOR_CYCLES cycles, then LED_G=0 and IDLE. The direction decision is re-evaluated from IDLE.
- Boundaries:
  - floor_cur never goes below 0 or above N_FLOORS-1, because direction is only chosen toward a pending bit.
  - A request for floor_cur during MOVE, when the car is between floors, is set in pending and served on a later pass.
  - Request edge in the same cycle a floor is cleared on arrival, same floor: the clear wins (the request is served).
  - Request edge in the same cycle a floor is cleared on arrival, different floor: both take effect.
  - New requests during DOOR are latched but do not shorten the door time. Only a same-floor request extends it.
  - A single KEY0 press registers exactly once, however long it is held.
  - RESET asserted mid-MOVE or mid-DOOR returns to reset values immediately. The car reports floor 0 and no position is retained.

Test Plan:
(Bench parameters: STEP_CYCLES=4, DOOR_CYCLES=6; a KEY0 "press" is a low pulse of at least 3 clocks with SW held stable.)
- Reset, then SW=9'b000001000 and press -> pending=0x008 on the 3rd edge; moving=1; floor_cur reaches 3 after 12 move cycles; LED_G=1 for 6 cycles; pending=0; final IDLE.
- SW=9'b000000101 (multi-hot) press; SW=0 press -> pending stays 0, state stays IDLE, LED_R=1 throughout.
- Car idle at floor 0, press floor 0 -> no movement; LED_G=1 for 6 cycles. A second press during DOOR extends it to 6 cycles after the second effective edge.
- Car at 2 moving up toward 6, request floor 4 and then floor 1 while in MOVE -> stops at 4 (door), then 6 (door), then reverses with dir_up=0 and stops at 1.
- Request floor 8 at N_FLOORS=9 -> reaches floor 8 and does not exceed it; dir_up stays 1 until a lower request arrives.
- Assert RESET while moving between floors 3 and 4 -> same cycle: floor_cur=0, pending=0, moving=0, LED_R=1; after release the block is idle and accepts a new request normally.
